hpdcache_sram_ecc_rmw_ctrl: RTL and testbench
=============================================

Name: hpdcache_sram_ecc_rmw_ctrl

Overview:
- Sequencing controller placed in front of the hpdcache 1RW ECC SRAM with write byte-enable.
- The ECC SRAM supports only full-word writes. This block converts sparse byte-enable writes into read-modify-write sequences.
- It scrubs words that report a correctable error on read, and counts error events.
- It has a single valid/ready requester port on one side and the raw SRAM command/data/error signals on the other.

Parameters:
- ADDR_SIZE, 8: SRAM address width.
- DATA_SIZE, 64: word width in bits, multiple of 8.
- NDATA, 1: words per SRAM row.
- CNT_WIDTH, 16: width of the saturating error counters.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready.
- req_we_i, in, 1: 1 = write, 0 = read.
- req_addr_i, in, ADDR_SIZE: row address.
- req_wdata_i, in, NDATA*DATA_SIZE: write data.
- req_wbe_i, in, NDATA*DATA_SIZE/8: byte enables.
- rsp_valid_o, out, 1: read response valid, single-cycle pulse.
- rsp_rdata_o, out, NDATA*DATA_SIZE: corrected read data.
- rsp_err_cor_o, out, NDATA: correctable error per word.
- rsp_err_unc_o, out, NDATA: uncorrectable error per word.
- rmw_abort_o, out, 1: pulse; a partial write was dropped because of an uncorrectable error.
- cfg_scrub_en_i, in, 1: enable write-back of corrected data.
- cnt_cor_o, out, CNT_WIDTH: saturating count of correctable events.
- cnt_unc_o, out, CNT_WIDTH: saturating count of uncorrectable events.
- cnt_clr_i, in, 1: synchronous clear of both counters.
- sram_cs_o, out, 1: SRAM chip select.
- sram_we_o, out, 1: SRAM write enable.
- sram_addr_o, out, ADDR_SIZE: SRAM address.
- sram_wdata_o, out, NDATA*DATA_SIZE: SRAM write data.
- sram_wbe_o, out, NDATA*DATA_SIZE/8: SRAM byte enables.
- sram_rdata_i, in, NDATA*DATA_SIZE: SRAM read data, valid one cycle after a read.
- sram_err_cor_i, in, NDATA: SRAM correctable error flags.
- sram_err_unc_i, in, NDATA: SRAM uncorrectable error flags.

Behaviour:
- States: IDLE, RD_WAIT, RMW_RD, RMW_WR, SCRUB_WR.
- Reset: state = IDLE. All outputs are 0 except req_ready_o = 1. Counters = 0.
- Reset asserted mid-sequence aborts the sequence. No write is issued and no response is given.
- req_ready_o = 1 only in IDLE.
- In IDLE, the SRAM command is driven combinationally from the accepted request in the same cycle.
- Per-word write classification:
  - Full: all enables set.
  - Empty: none set.
  - Sparse: otherwise.
- Write, every word full or empty: sram_cs = 1, sram_we = 1, wbe passed through. State stays IDLE; throughput 1 per cycle.
- Write, all enables zero: accepted with no SRAM access.
- Write, any word sparse: issue a read at req_addr_i, latch addr/wdata/wbe, go to RMW_RD.
- RMW_RD (read data valid):
  - Any err_unc: no write, rmw_abort_o pulses, cnt_unc increments, go to IDLE.
  - Otherwise: register the byte merge (wdata where wbe = 1, else rdata) and go to RMW_WR.
  - Any err_cor increments cnt_cor.
- RMW_WR: write the merged data with all enables set to 1 for every word that has at least one enable; untouched words get wbe = 0. Go to IDLE.
- Partial write occupancy is 3 cycles.
- Read: issue cs = 1, we = 0; go to RD_WAIT.
- RD_WAIT:
  - rsp_valid_o = 1 with rdata and flags (read latency 2 from acceptance).
  - Counters update.
  - If any err_cor, no err_unc, and cfg_scrub_en_i: latch corrected data, go to SCRUB_WR. Otherwise go to IDLE.
- SCRUB_WR: write the latched data with wbe set for the words with err_cor only. Go to IDLE.
- Counters increment by 1 per event cycle regardless of how many words flagged the error, and saturate at all-ones.
- cnt_clr_i has priority over an increment in the same cycle.
- cfg_scrub_en_i is sampled in RD_WAIT.
- sram_* outputs are 0 whenever no access is issued.

Decomposition:
- Package hpdcache_sram_ecc_ctrl_pkg: state enum typedef, and functions is_full_be/is_sparse_be.
- One sub-module, hpdcache_ecc_byte_merge: combinational per-byte mux of wdata/rdata under wbe, parameterized by DATA_SIZE and NDATA.

Test Plan:
- Full write: addr 0x12, data 0xA5A5..., wbe 0xFF. Required: same-cycle SRAM write with wbe 0xFF; a read of 0x12 returns the data 2 cycles after acceptance with flags 0.
- Sparse write: wbe 0x0F, new 0x11223344 over stored 0xDEADBEEFCAFEF00D. Required: read, then write of 0xDEADBEEF11223344 with wbe 0xFF; ready is low for 2 cycles.
- RMW with sram_err_unc_i = 1 on the read. Required: no write issued, rmw_abort_o pulses 1 cycle, cnt_unc = 1.
- Read with err_cor = 1 and cfg_scrub_en_i = 1. Required: rsp_valid with err_cor, then a SCRUB_WR full write of the corrected data, cnt_cor = 1. With cfg_scrub_en_i = 0: no write.
- Counter saturation: CNT_WIDTH = 2, 5 correctable reads. Required: cnt_cor = 3. cnt_clr_i together with an event yields 0.
- Reset asserted in RMW_RD. Required: no SRAM write, state IDLE, req_ready_o = 1 after release.

Source files
------------

// File: rtl/hpdcache_sram_ecc_ctrl_pkg.sv
// Shared types and byte-enable helpers for the ECC SRAM read-modify-write controller.
package hpdcache_sram_ecc_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RMW_RD,
        RMW_WR,
        SCRUB_WR
    } ctrl_state_e;

    // Widest word (in bytes) the byte-enable helpers can classify.
    localparam int unsigned MAX_WORD_BYTES = 64;

    typedef logic [MAX_WORD_BYTES-1:0] word_be_t;

    // True when every one of the first nbytes enables is set.
    function automatic logic is_full_be(input word_be_t be, input int unsigned nbytes);
        logic full;
        full = 1'b1;
        for (int unsigned i = 0; i < MAX_WORD_BYTES; i++) begin
            if ((i < nbytes) && !be[i]) full = 1'b0;
        end
        return full;
    endfunction

    // True when some but not all of the first nbytes enables are set.
    function automatic logic is_sparse_be(input word_be_t be, input int unsigned nbytes);
        logic any;
        any = 1'b0;
        for (int unsigned i = 0; i < MAX_WORD_BYTES; i++) begin
            if ((i < nbytes) && be[i]) any = 1'b1;
        end
        return any && !is_full_be(be, nbytes);
    endfunction

endpackage

// File: rtl/hpdcache_ecc_byte_merge.sv
// Per-byte merge of new write data over data read back from the SRAM.
module hpdcache_ecc_byte_merge #(
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned NDATA     = 1
) (
    input  logic [NDATA*DATA_SIZE-1:0]   i_wdata,
    input  logic [NDATA*DATA_SIZE-1:0]   i_rdata,
    input  logic [NDATA*DATA_SIZE/8-1:0] i_wbe,
    output logic [NDATA*DATA_SIZE-1:0]   o_merged
);

    localparam int unsigned NBYTES = NDATA * DATA_SIZE / 8;

    // Each byte comes from the write data when enabled, otherwise from the stored word.
    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
        assign o_merged[b*8 +: 8] = i_wbe[b] ? i_wdata[b*8 +: 8] : i_rdata[b*8 +: 8];
    end

endmodule

// File: rtl/hpdcache_sram_ecc_rmw_ctrl.sv
// Front-end sequencer for a full-word-write ECC SRAM: turns sparse byte-enable
// writes into read-modify-write, scrubs correctable read errors, counts events.
module hpdcache_sram_ecc_rmw_ctrl
    import hpdcache_sram_ecc_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned NDATA     = 1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_we_i,
    input  logic [ADDR_SIZE-1:0]           req_addr_i,
    input  logic [NDATA*DATA_SIZE-1:0]     req_wdata_i,
    input  logic [NDATA*DATA_SIZE/8-1:0]   req_wbe_i,

    output logic                           rsp_valid_o,
    output logic [NDATA*DATA_SIZE-1:0]     rsp_rdata_o,
    output logic [NDATA-1:0]               rsp_err_cor_o,
    output logic [NDATA-1:0]               rsp_err_unc_o,
    output logic                           rmw_abort_o,

    input  logic                           cfg_scrub_en_i,
    output logic [CNT_WIDTH-1:0]           cnt_cor_o,
    output logic [CNT_WIDTH-1:0]           cnt_unc_o,
    input  logic                           cnt_clr_i,

    output logic                           sram_cs_o,
    output logic                           sram_we_o,
    output logic [ADDR_SIZE-1:0]           sram_addr_o,
    output logic [NDATA*DATA_SIZE-1:0]     sram_wdata_o,
    output logic [NDATA*DATA_SIZE/8-1:0]   sram_wbe_o,
    input  logic [NDATA*DATA_SIZE-1:0]     sram_rdata_i,
    input  logic [NDATA-1:0]               sram_err_cor_i,
    input  logic [NDATA-1:0]               sram_err_unc_i
);

    localparam int unsigned WORD_BYTES = DATA_SIZE / 8;
    localparam int unsigned DW         = NDATA * DATA_SIZE;
    localparam int unsigned BEW        = NDATA * WORD_BYTES;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    ctrl_state_e            r_state;
    ctrl_state_e            w_state_next;

    logic [ADDR_SIZE-1:0]   r_addr;
    logic [DW-1:0]          r_data;
    logic [BEW-1:0]         r_wbe;
    logic [NDATA-1:0]       r_scrub_words;
    logic [CNT_WIDTH-1:0]   r_cnt_cor;
    logic [CNT_WIDTH-1:0]   r_cnt_unc;

    logic [NDATA-1:0]       w_word_sparse;
    logic [BEW-1:0]         w_rmw_wbe;
    logic [BEW-1:0]         w_scrub_wbe;
    logic [DW-1:0]          w_merged;
    logic                   w_any_sparse;
    logic                   w_any_be;
    logic                   w_any_cor;
    logic                   w_any_unc;
    logic                   w_latch_req;
    logic                   w_latch_merge;
    logic                   w_latch_scrub;
    logic                   w_inc_cor;
    logic                   w_inc_unc;

    // Per-word classification of the incoming enables and of the latched ones.
    for (genvar w = 0; w < NDATA; w++) begin : g_word
        word_be_t w_be_ext;
        assign w_be_ext         = word_be_t'(req_wbe_i[w*WORD_BYTES +: WORD_BYTES]);
        assign w_word_sparse[w] = is_sparse_be(w_be_ext, WORD_BYTES);
        // A word touched by the request is rewritten whole with the merged data.
        assign w_rmw_wbe[w*WORD_BYTES +: WORD_BYTES]   = {WORD_BYTES{|r_wbe[w*WORD_BYTES +: WORD_BYTES]}};
        assign w_scrub_wbe[w*WORD_BYTES +: WORD_BYTES] = {WORD_BYTES{r_scrub_words[w]}};
    end

    assign w_any_sparse = |w_word_sparse;
    assign w_any_be     = |req_wbe_i;
    assign w_any_cor    = |sram_err_cor_i;
    assign w_any_unc    = |sram_err_unc_i;

    hpdcache_ecc_byte_merge #(
        .DATA_SIZE (DATA_SIZE),
        .NDATA     (NDATA)
    ) u_byte_merge (
        .i_wdata   (r_data),
        .i_rdata   (sram_rdata_i),
        .i_wbe     (r_wbe),
        .o_merged  (w_merged)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state, SRAM command, response and event decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned
        // (which would infer a latch).
        w_state_next  = r_state;
        req_ready_o   = 1'b0;
        rsp_valid_o   = 1'b0;
        rsp_rdata_o   = '0;
        rsp_err_cor_o = '0;
        rsp_err_unc_o = '0;
        rmw_abort_o   = 1'b0;
        sram_cs_o     = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = '0;
        sram_wdata_o  = '0;
        sram_wbe_o    = '0;
        w_latch_req   = 1'b0;
        w_latch_merge = 1'b0;
        w_latch_scrub = 1'b0;
        w_inc_cor     = 1'b0;
        w_inc_unc     = 1'b0;

        unique case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (req_we_i) begin
                        if (w_any_sparse) begin
                            sram_cs_o    = 1'b1;
                            sram_addr_o  = req_addr_i;
                            w_latch_req  = 1'b1;
                            w_state_next = RMW_RD;
                        end else if (w_any_be) begin
                            sram_cs_o    = 1'b1;
                            sram_we_o    = 1'b1;
                            sram_addr_o  = req_addr_i;
                            sram_wdata_o = req_wdata_i;
                            sram_wbe_o   = req_wbe_i;
                        end
                    end else begin
                        sram_cs_o    = 1'b1;
                        sram_addr_o  = req_addr_i;
                        w_latch_req  = 1'b1;
                        w_state_next = RD_WAIT;
                    end
                end
            end

            RD_WAIT: begin
                rsp_valid_o   = 1'b1;
                rsp_rdata_o   = sram_rdata_i;
                rsp_err_cor_o = sram_err_cor_i;
                rsp_err_unc_o = sram_err_unc_i;
                w_inc_cor     = w_any_cor;
                w_inc_unc     = w_any_unc;
                if (w_any_cor && !w_any_unc && cfg_scrub_en_i) begin
                    w_latch_scrub = 1'b1;
                    w_state_next  = SCRUB_WR;
                end else begin
                    w_state_next  = IDLE;
                end
            end

            RMW_RD: begin
                w_inc_cor = w_any_cor;
                if (w_any_unc) begin
                    rmw_abort_o  = 1'b1;
                    w_inc_unc    = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_latch_merge = 1'b1;
                    w_state_next  = RMW_WR;
                end
            end

            RMW_WR: begin
                sram_cs_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = r_addr;
                sram_wdata_o = r_data;
                sram_wbe_o   = w_rmw_wbe;
                w_state_next = IDLE;
            end

            SCRUB_WR: begin
                sram_cs_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = r_addr;
                sram_wdata_o = r_data;
                sram_wbe_o   = w_scrub_wbe;
                w_state_next = IDLE;
            end

            default: w_state_next = IDLE;
        endcase
    end

    // Sequence context: request capture, then merged or corrected data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: these are plain datapath registers, so clearing them on reset is
        // cheap and keeps outputs deterministic; only the FSM actually needs it.
        if (!rst_ni) begin
            r_addr        <= '0;
            r_data        <= '0;
            r_wbe         <= '0;
            r_scrub_words <= '0;
        end else begin
            if (w_latch_req) begin
                r_addr <= req_addr_i;
                r_data <= req_wdata_i;
                r_wbe  <= req_wbe_i;
            end
            if (w_latch_merge) begin
                r_data <= w_merged;
            end
            if (w_latch_scrub) begin
                r_data        <= sram_rdata_i;
                r_scrub_words <= sram_err_cor_i;
            end
        end
    end

    // Saturating event counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt_cor <= '0;
            r_cnt_unc <= '0;
        end else if (cnt_clr_i) begin
            r_cnt_cor <= '0;
            r_cnt_unc <= '0;
        end else begin
            if (w_inc_cor && (r_cnt_cor != CNT_MAX)) r_cnt_cor <= r_cnt_cor + CNT_WIDTH'(1);
            if (w_inc_unc && (r_cnt_unc != CNT_MAX)) r_cnt_unc <= r_cnt_unc + CNT_WIDTH'(1);
        end
    end

    assign cnt_cor_o = r_cnt_cor;
    assign cnt_unc_o = r_cnt_unc;

endmodule

// File: tb/tb_hpdcache_sram_ecc_rmw_ctrl.sv
// Directed testbench for the ECC SRAM read-modify-write controller.
// A behavioural 1RW SRAM sits behind the main instance; a second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_hpdcache_sram_ecc_rmw_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wbe;
    logic        cfg_scrub_en;
    logic        cnt_clr;
    logic        err_cor;
    logic        err_unc;

    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err_cor;
    logic        rsp_err_unc;
    logic        rmw_abort;
    logic [15:0] cnt_cor;
    logic [15:0] cnt_unc;
    logic        sram_cs;
    logic        sram_we;
    logic [7:0]  sram_addr;
    logic [63:0] sram_wdata;
    logic [7:0]  sram_wbe;
    logic [63:0] sram_rdata;

    logic        sat_ready;
    logic        sat_rsp_valid;
    logic [63:0] sat_rsp_rdata;
    logic        sat_rsp_err_cor;
    logic        sat_rsp_err_unc;
    logic        sat_rmw_abort;
    logic [1:0]  sat_cnt_cor;
    logic [1:0]  sat_cnt_unc;
    logic        sat_cs;
    logic        sat_we;
    logic [7:0]  sat_addr;
    logic [63:0] sat_wdata;
    logic [7:0]  sat_wbe;

    int n_checks = 0;
    int n_errors = 0;

    hpdcache_sram_ecc_rmw_ctrl #(
        .ADDR_SIZE(8), .DATA_SIZE(64), .NDATA(1), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wbe_i(req_wbe),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .rsp_err_cor_o(rsp_err_cor), .rsp_err_unc_o(rsp_err_unc),
        .rmw_abort_o(rmw_abort), .cfg_scrub_en_i(cfg_scrub_en),
        .cnt_cor_o(cnt_cor), .cnt_unc_o(cnt_unc), .cnt_clr_i(cnt_clr),
        .sram_cs_o(sram_cs), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_wbe_o(sram_wbe),
        .sram_rdata_i(sram_rdata), .sram_err_cor_i(err_cor), .sram_err_unc_i(err_unc)
    );

    hpdcache_sram_ecc_rmw_ctrl #(
        .ADDR_SIZE(8), .DATA_SIZE(64), .NDATA(1), .CNT_WIDTH(2)
    ) dut_sat (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(sat_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wbe_i(req_wbe),
        .rsp_valid_o(sat_rsp_valid), .rsp_rdata_o(sat_rsp_rdata),
        .rsp_err_cor_o(sat_rsp_err_cor), .rsp_err_unc_o(sat_rsp_err_unc),
        .rmw_abort_o(sat_rmw_abort), .cfg_scrub_en_i(cfg_scrub_en),
        .cnt_cor_o(sat_cnt_cor), .cnt_unc_o(sat_cnt_unc), .cnt_clr_i(cnt_clr),
        .sram_cs_o(sat_cs), .sram_we_o(sat_we), .sram_addr_o(sat_addr),
        .sram_wdata_o(sat_wdata), .sram_wbe_o(sat_wbe),
        .sram_rdata_i(sram_rdata), .sram_err_cor_i(err_cor), .sram_err_unc_i(err_unc)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1RW SRAM: byte-masked write, read data valid the next cycle.
    logic [63:0] mem [256];
    logic [63:0] sram_rdata_q;
    int          wr_count;
    assign sram_rdata = sram_rdata_q;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        sram_rdata_q = '0;
        wr_count     = 0;
    end

    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_wbe[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                wr_count <= wr_count + 1;
            end else begin
                sram_rdata_q <= mem[sram_addr];
            end
        end
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wbe   = '0;
    endtask

    task automatic pulse_clear();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        cfg_scrub_en = 1'b0;
        cnt_clr = 1'b0;
        err_cor = 1'b0;
        err_unc = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_checks++; if ({sram_cs, sram_we, sram_wbe} !== 10'd0) begin n_errors++; $display("FAIL reset_sram: cs=%b we=%b wbe=%h want 0", sram_cs, sram_we, sram_wbe); end
        n_checks++; if ({rsp_valid, rmw_abort} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: rsp_valid=%b abort=%b want 0", rsp_valid, rmw_abort); end
        n_checks++; if ({cnt_cor, cnt_unc} !== 32'd0) begin n_errors++; $display("FAIL reset_counters: cor=%0d unc=%0d want 0", cnt_cor, cnt_unc); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_full_write_read();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12;
        req_wdata = 64'hA5A5_A5A5_A5A5_A5A5; req_wbe = 8'hFF;
        @(negedge clk);
        n_checks++; if ({sram_cs, sram_we, req_ready} !== 3'b111) begin n_errors++; $display("FAIL full_wr_cmd: cs=%b we=%b ready=%b want 111", sram_cs, sram_we, req_ready); end
        n_checks++; if ({sram_addr, sram_wbe} !== {8'h12, 8'hFF}) begin n_errors++; $display("FAIL full_wr_addr_wbe: addr=%h wbe=%h want 12 ff", sram_addr, sram_wbe); end
        n_checks++; if (sram_wdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_errors++; $display("FAIL full_wr_data: got %h want a5a5a5a5a5a5a5a5", sram_wdata); end
        tick();
        req_we = 1'b0; req_wdata = '0; req_wbe = '0;
        @(negedge clk);
        n_checks++; if ({sram_cs, sram_we, req_ready} !== 3'b101) begin n_errors++; $display("FAIL read_cmd: cs=%b we=%b ready=%b want 101", sram_cs, sram_we, req_ready); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_err_cor, rsp_err_unc, req_ready} !== 4'b1000) begin n_errors++; $display("FAIL read_rsp_flags: valid=%b cor=%b unc=%b ready=%b want 1000", rsp_valid, rsp_err_cor, rsp_err_unc, req_ready); end
        n_checks++; if (rsp_rdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_errors++; $display("FAIL read_rsp_data: got %h want a5a5a5a5a5a5a5a5", rsp_rdata); end
        tick();
        @(negedge clk);
        n_checks++; if ({rsp_valid, req_ready, sram_cs} !== 3'b010) begin n_errors++; $display("FAIL read_done: valid=%b ready=%b cs=%b want 010", rsp_valid, req_ready, sram_cs); end
    endtask

    task automatic test_back_to_back();
        int wr_before;
        wr_before = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20;
        req_wdata = 64'h0102_0304_0506_0708; req_wbe = 8'hFF;
        @(negedge clk);
        n_checks++; if ({sram_cs, sram_we, req_ready} !== 3'b111) begin n_errors++; $display("FAIL b2b_first: cs=%b we=%b ready=%b want 111", sram_cs, sram_we, req_ready); end
        tick();
        req_addr = 8'h21; req_wdata = 64'h1112_1314_1516_1718;
        @(negedge clk);
        n_checks++; if ({sram_cs, sram_we, req_ready, sram_addr} !== {3'b111, 8'h21}) begin n_errors++; $display("FAIL b2b_second: cs=%b we=%b ready=%b addr=%h want 111 21", sram_cs, sram_we, req_ready, sram_addr); end
        tick();
        req_addr = 8'h22; req_wbe = 8'h00;
        @(negedge clk);
        n_checks++; if ({sram_cs, req_ready} !== 2'b01) begin n_errors++; $display("FAIL empty_wbe: cs=%b ready=%b want 01", sram_cs, req_ready); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if (wr_count - wr_before !== 2) begin n_errors++; $display("FAIL b2b_write_count: got %0d want 2", wr_count - wr_before); end
        n_checks++; if ({mem[8'h20], mem[8'h21]} !== {64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718}) begin n_errors++; $display("FAIL b2b_mem: got %h %h", mem[8'h20], mem[8'h21]); end
        n_checks++; if (mem[8'h22] !== 64'd0) begin n_errors++; $display("FAIL empty_wbe_mem: got %h want 0", mem[8'h22]); end
    endtask

    task automatic test_sparse_write();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30;
        req_wdata = 64'hDEAD_BEEF_CAFE_F00D; req_wbe = 8'hFF;
        tick();
        req_wdata = 64'h0000_0000_1122_3344; req_wbe = 8'h0F;
        @(negedge clk);
        n_checks++; if ({sram_cs, sram_we, req_ready, sram_addr} !== {3'b101, 8'h30}) begin n_errors++; $display("FAIL rmw_read_cmd: cs=%b we=%b ready=%b addr=%h want 101 30", sram_cs, sram_we, req_ready, sram_addr); end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++; if ({req_ready, sram_cs} !== 2'b00) begin n_errors++; $display("FAIL rmw_rd_state: ready=%b cs=%b want 00", req_ready, sram_cs); end
        tick();
        @(negedge clk);
        n_checks++; if ({req_ready, sram_cs, sram_we, sram_wbe} !== {3'b011, 8'hFF}) begin n_errors++; $display("FAIL rmw_wr_cmd: ready=%b cs=%b we=%b wbe=%h want 011 ff", req_ready, sram_cs, sram_we, sram_wbe); end
        n_checks++; if (sram_wdata !== 64'hDEAD_BEEF_1122_3344) begin n_errors++; $display("FAIL rmw_merge: got %h want deadbeef11223344", sram_wdata); end
        tick();
        @(negedge clk);
        n_checks++; if ({req_ready, sram_cs} !== 2'b10) begin n_errors++; $display("FAIL rmw_done: ready=%b cs=%b want 10", req_ready, sram_cs); end
        n_checks++; if (mem[8'h30] !== 64'hDEAD_BEEF_1122_3344) begin n_errors++; $display("FAIL rmw_mem: got %h want deadbeef11223344", mem[8'h30]); end
    endtask

    task automatic test_rmw_unc();
        int wr_before;
        wr_before = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30;
        req_wdata = 64'h0000_0000_0000_00FF; req_wbe = 8'h01;
        tick();
        idle_inputs();
        err_unc = 1'b1;
        @(negedge clk);
        n_checks++; if ({rmw_abort, sram_cs} !== 2'b10) begin n_errors++; $display("FAIL unc_abort: abort=%b cs=%b want 10", rmw_abort, sram_cs); end
        tick();
        err_unc = 1'b0;
        @(negedge clk);
        n_checks++; if ({rmw_abort, sram_cs, req_ready} !== 3'b001) begin n_errors++; $display("FAIL unc_after: abort=%b cs=%b ready=%b want 001", rmw_abort, sram_cs, req_ready); end
        n_checks++; if (cnt_unc !== 16'd1) begin n_errors++; $display("FAIL unc_count: got %0d want 1", cnt_unc); end
        n_checks++; if ((wr_count - wr_before !== 0) || (mem[8'h30] !== 64'hDEAD_BEEF_1122_3344)) begin n_errors++; $display("FAIL unc_no_write: writes=%0d mem=%h", wr_count - wr_before, mem[8'h30]); end
    endtask

    task automatic test_scrub();
        pulse_clear();
        @(negedge clk);
        n_checks++; if ({cnt_cor, cnt_unc} !== 32'd0) begin n_errors++; $display("FAIL clear: cor=%0d unc=%0d want 0", cnt_cor, cnt_unc); end
        // Scrub enabled: response, then write-back of the corrected word.
        cfg_scrub_en = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
        tick();
        idle_inputs();
        err_cor = 1'b1;
        @(negedge clk);
        n_checks++; if ({rsp_valid, rsp_err_cor, rsp_err_unc} !== 3'b110) begin n_errors++; $display("FAIL scrub_rsp: valid=%b cor=%b unc=%b want 110", rsp_valid, rsp_err_cor, rsp_err_unc); end
        tick();
        err_cor = 1'b0;
        @(negedge clk);
        n_checks++; if ({sram_cs, sram_we, sram_addr, sram_wbe, req_ready} !== {2'b11, 8'h12, 8'hFF, 1'b0}) begin n_errors++; $display("FAIL scrub_wr_cmd: cs=%b we=%b addr=%h wbe=%h ready=%b", sram_cs, sram_we, sram_addr, sram_wbe, req_ready); end
        n_checks++; if (sram_wdata !== 64'hA5A5_A5A5_A5A5_A5A5) begin n_errors++; $display("FAIL scrub_wr_data: got %h want a5a5a5a5a5a5a5a5", sram_wdata); end
        n_checks++; if (cnt_cor !== 16'd1) begin n_errors++; $display("FAIL scrub_count: got %0d want 1", cnt_cor); end
        tick();
        // Scrub disabled: response only, no write-back.
        cfg_scrub_en = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
        tick();
        idle_inputs();
        err_cor = 1'b1;
        tick();
        err_cor = 1'b0;
        @(negedge clk);
        n_checks++; if ({sram_cs, req_ready} !== 2'b01) begin n_errors++; $display("FAIL noscrub: cs=%b ready=%b want 01", sram_cs, req_ready); end
        n_checks++; if (cnt_cor !== 16'd2) begin n_errors++; $display("FAIL noscrub_count: got %0d want 2", cnt_cor); end
    endtask

    task automatic cor_read();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
        tick();
        idle_inputs();
        err_cor = 1'b1;
        tick();
        err_cor = 1'b0;
    endtask

    task automatic test_cnt_saturation();
        cfg_scrub_en = 1'b0;
        pulse_clear();
        for (int i = 0; i < 3; i++) cor_read();
        @(negedge clk);
        n_checks++; if ({sat_cnt_cor, cnt_cor} !== {2'd3, 16'd3}) begin n_errors++; $display("FAIL cnt_three: sat=%0d main=%0d want 3 3", sat_cnt_cor, cnt_cor); end
        tick();
        for (int i = 0; i < 2; i++) cor_read();
        @(negedge clk);
        n_checks++; if ({sat_cnt_cor, cnt_cor} !== {2'd3, 16'd5}) begin n_errors++; $display("FAIL cnt_saturate: sat=%0d main=%0d want 3 5", sat_cnt_cor, cnt_cor); end
        tick();
        // Clear in the same cycle as a correctable event.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h12;
        tick();
        idle_inputs();
        err_cor = 1'b1;
        cnt_clr = 1'b1;
        tick();
        err_cor = 1'b0;
        cnt_clr = 1'b0;
        @(negedge clk);
        n_checks++; if ({sat_cnt_cor, cnt_cor} !== 18'd0) begin n_errors++; $display("FAIL clr_priority: sat=%0d main=%0d want 0 0", sat_cnt_cor, cnt_cor); end
    endtask

    task automatic test_reset_mid_rmw();
        int wr_before;
        wr_before = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30;
        req_wdata = 64'h0000_0000_0000_0077; req_wbe = 8'h01;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if ({req_ready, sram_cs} !== 2'b10) begin n_errors++; $display("FAIL rst_mid_hold: ready=%b cs=%b want 10", req_ready, sram_cs); end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if ({req_ready, sram_cs} !== 2'b10) begin n_errors++; $display("FAIL rst_mid_after: ready=%b cs=%b want 10", req_ready, sram_cs); end
        n_checks++; if ((wr_count - wr_before !== 0) || (mem[8'h30] !== 64'hDEAD_BEEF_1122_3344)) begin n_errors++; $display("FAIL rst_mid_no_write: writes=%0d mem=%h", wr_count - wr_before, mem[8'h30]); end
    endtask

    initial begin
        test_reset();
        tick();
        test_full_write_read();
        tick();
        test_back_to_back();
        tick();
        test_sparse_write();
        tick();
        test_rmw_unc();
        tick();
        test_scrub();
        tick();
        test_cnt_saturation();
        tick();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
